// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: R-type funct
// codes decoded by muldiv_unit and the sequencer state encoding.
package muldiv_unit_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// One iteration of the muldiv datapath.
//   mode=0: shift-add multiply step on {partial_hi, multiplier_lo}.
//   mode=1: restoring divide step on {remainder, dividend/quotient}.
module muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] trial;

    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    // One extra bit so the borrow is exact even when the shifted remainder
    // reaches WIDTH+1 bits (divisor of zero or near full scale).
    assign trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};

    // Select the multiply or divide iteration.
    always_comb begin
        acc_next = acc;
        if (!mode) begin
            if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
            else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            if (!trial[WIDTH+1]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                 acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Optional build macro: MULDIV_DIV0_FLAG_EN adds a div0 output and makes a
// divide by zero skip the iterations (IDLE goes straight to FIX).
//
// state   | meaning
// MD_IDLE | waiting; MTHI/MTLO write directly, arithmetic ops launch
// MD_MUL  | one shift-add step per cycle, WIDTH steps
// MD_DIV  | one restoring-divide step per cycle, WIDTH steps
// MD_FIX  | sign correction, HI/LO write, done pulse
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic             div0,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               neg_q_q, neg_q_d;   // product / quotient sign
    logic               neg_r_q, neg_r_d;   // remainder sign
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;         // divisor was zero
    logic               busy_q, busy_d, done_q, done_d;
    logic               div0_q, div0_d;

    logic               op_signed;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign op_signed = (funct == F_MULT) || (funct == F_DIV);
    assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;
    assign prod      = neg_q_q ? -acc_q : acc_q;
    assign quo       = dz_q ? '1 : (neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem       = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
        .mode     (state_q == MD_DIV),
        .acc      (acc_q),
        .operand  (op_q),
        .acc_next (acc_step)
    );

    // Next-state, datapath and HI/LO write decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    case (funct)
                        F_MTHI: hi_d = a;
                        F_MTLO: lo_d = a;
                        F_MULT, F_MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, mag_b};
                            op_d     = mag_a;
                            neg_q_d  = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_d  = 1'b0;
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = MD_MUL;
                        end
                        F_DIV, F_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, mag_a};
                            op_d     = mag_b;
                            neg_q_d  = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_d  = op_signed && a[WIDTH-1];
                            is_div_d = 1'b1;
                            dz_d     = (b == '0);
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = MD_DIV;
`ifdef MULDIV_DIV0_FLAG_EN
                            // Same accumulator the full iteration would reach.
                            if (b == '0) begin
                                acc_d   = {mag_a, {WIDTH{1'b1}}};
                                state_d = MD_FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            MD_MUL, MD_DIV: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                if (is_div_q) begin
                    lo_d = quo;
                    hi_d = rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                div0_d  = is_div_q && dz_q;
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush) begin
            state_d = MD_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            div0_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // Sequencer, accumulator and architectural HI/LO registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
    assign div0 = div0_q;
`else
    logic unused_div0;
    assign unused_div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; also builds with MULDIV_DIV0_FLAG_EN.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h00;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div0;
    localparam int DIV0_BUSY = 1;
`else
    logic        div0 = 1'b0;
    localparam int DIV0_BUSY = 33;
`endif

    int tests = 0;
    int failed = 0;
    int busy_cyc, done_cnt, div0_cnt, dcount;

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
`ifdef MULDIV_DIV0_FLAG_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge for one cycle.
    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1; funct = f; a = av; b = bv;
        @(negedge clock);
        start = 1'b0; funct = 6'h00; a = '0; b = '0;
    endtask

    // Count busy cycles and done/div0 pulses until busy drops (bounded).
    task automatic wait_done(output int bc, output int dc, output int zc);
        bc = 0; dc = 0; zc = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) dc++;
            if (div0) zc++;
            if (!busy) break;
            bc++;
            @(negedge clock);
        end
        @(negedge clock);
        if (done) dc++;
        if (div0) zc++;
    endtask

    task automatic run(input string tag, input logic [5:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input int exp_busy,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(f, av, bv);
        wait_done(busy_cyc, done_cnt, div0_cnt);
        check({tag, " busy"}, 64'(busy_cyc), 64'(exp_busy));
        check({tag, " done"}, 64'(done_cnt), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run("mult -2*3", 6'h18, 32'hFFFFFFFE, 32'h3, 33, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h1);
        run("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu 7/2", 6'h1B, 32'h7, 32'h2, 33, 32'h1, 32'h3);
        run("div ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);

        // MTHI/MTLO write at the edge, no busy, no done.
        issue(6'h11, 32'h12345678, 32'h0);
        check("mthi hi", 64'(hi), 64'h12345678);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        issue(6'h13, 32'hCAFEF00D, 32'h0);
        check("mtlo lo", 64'(lo), 64'hCAFEF00D);

        // MULT flushed at cycle 5.
        issue(6'h18, 32'h7, 32'h9);
        repeat (3) @(negedge clock);
        check("pre-flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcount++;
            @(negedge clock);
        end
        check("flush no done", 64'(dcount), 64'd0);
        check("flush hi", 64'(hi), 64'h12345678);
        check("flush lo", 64'(lo), 64'hCAFEF00D);

        // Flush together with MTHI in IDLE: start ignored.
        flush = 1'b1;
        issue(6'h11, 32'hBAD0BAD0, 32'h0);
        flush = 1'b0;
        check("flush+mthi hi", 64'(hi), 64'h12345678);

        // Divide by zero, unsigned and signed.
        run("divu by 0", 6'h1B, 32'h55, 32'h0, DIV0_BUSY, 32'h55, 32'hFFFFFFFF);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div0 flag", 64'(div0_cnt), 64'd1);
`endif
        run("div by 0", 6'h1A, 32'hFFFFFFF0, 32'h0, DIV0_BUSY, 32'hFFFFFFF0, 32'hFFFFFFFF);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div0 flag s", 64'(div0_cnt), 64'd1);
`endif
        run("divu nz", 6'h1B, 32'h64, 32'h7, 33, 32'h2, 32'he);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div0 quiet", 64'(div0_cnt), 64'd0);
`endif

        // Start while busy is ignored.
        issue(6'h19, 32'h3, 32'h5);
        repeat (2) @(negedge clock);
        issue(6'h11, 32'hDEADBEEF, 32'h0);
        check("busy mthi hi", 64'(hi), 64'h2);
        issue(6'h1B, 32'h1, 32'h0);
        wait_done(busy_cyc, done_cnt, div0_cnt);
        check("busy ign cyc", 64'(busy_cyc + 4), 64'd33);
        check("busy ign done", 64'(done_cnt), 64'd1);
        check("busy ign hi", 64'(hi), 64'h0);
        check("busy ign lo", 64'(lo), 64'd15);
        check("busy ign div0", 64'(div0_cnt), 64'd0);

        // Asynchronous reset in the middle of a divide.
        issue(6'h1B, 32'h64, 32'h7);
        repeat (9) @(negedge clock);
        check("mid-div busy", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run("post-rst divu", 6'h1B, 32'h64, 32'h7, 33, 32'h2, 32'he);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair of the mips32 core.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the decode/execute stage.
- Runs 32-step shift-add multiply or restoring divide, and raises busy so the pipeline stalls any HI/LO consumer until the result lands.
- Sits beside the ALU in execute; the ALU never sees these funct codes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request valid for one cycle; funct/a/b qualified by it.
- funct  in  6  R-type funct code (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- a  in  WIDTH  rs operand (multiplicand / dividend / MTxx source).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort the in-flight operation (branch/exception squash).
- busy  out  1  operation in progress; pipeline stalls MFHI/MFLO/new muldiv.
- done  out  1  one-cycle pulse when HI/LO are written by an arithmetic op.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (async): state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start with MTHI: hi<=a at that edge; MTLO: lo<=a. No busy, no done.
- IDLE, start with MULT/MULTU: latch magnitudes (abs if signed), record result sign = a[31]^b[31] (signed only), counter<=0, go MUL.
- IDLE, start with DIV/DIVU: latch magnitudes, quotient sign = a[31]^b[31], remainder sign = a[31] (signed only), go DIV.
- IDLE, start with any other funct: ignored.
- MUL: one shift-add step per cycle over a 2*WIDTH product; after WIDTH steps go FIX.
- DIV: one restoring step per cycle; after WIDTH steps go FIX.
- FIX: apply two's-complement sign correction.
  - Multiply: {hi,lo}<=product.
  - Divide: lo<=quotient, hi<=remainder.
  - done=1 this cycle; next state IDLE.
- Timing: start sampled at edge E0. busy=1 from after E0 through the FIX cycle (WIDTH+1 cycles). hi/lo update at edge E(WIDTH+1). busy falls and done rises in the same cycle as the FIX write is presented.
- hi/lo hold their old values until the FIX write; intermediate work stays in private accumulators.
- start while busy: ignored; upstream must stall.
- flush: any state returns to IDLE at the next edge; hi/lo untouched, no done pulse. flush together with start in IDLE: start is ignored.
- Divide by zero (b=0): lo=all ones, hi=a, for both signed and unsigned. Uses full latency.
- Signed DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Counter wraps only via reset to 0 on entry to MUL/DIV.

Optional Feature:
- Macro: MULDIV_DIV0_FLAG_EN.
- Defined:
  - Adds output port div0 (1 bit, reset 0).
  - DIV/DIVU with b=0 skips the iterations: IDLE goes directly to FIX (busy for 1 cycle).
  - Writes lo=all ones and hi=a.
  - div0 pulses together with done.
- Undefined: no div0 port; divide-by-zero runs the full WIDTH+1 cycles with the same hi/lo result.

Decomposition:
- parameters.v (shared) gains:
  - funct defines MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MTHI 6'h11, MTLO 6'h13, MFHI 6'h10, MFLO 6'h12.
  - state encodings MD_IDLE, MD_MUL, MD_DIV, MD_FIX.
- One natural sub-module: muldiv_step, the combinational single-iteration datapath (add-shift or trial-subtract selected by a mode bit).
- The FSM, counter and HI/LO registers stay in muldiv_unit.

Test Plan:
- Reset mid-DIV (assert at cycle 10) -> busy=0, hi=lo=0 immediately; next start behaves normally.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MTHI 0x12345678 then MULT started and flushed at cycle 5 -> hi stays 0x12345678, no done, busy=0 next cycle.
- DIV b=0, a=0x55 -> lo=0xFFFFFFFF, hi=0x55. With MULTU_DIV0_FLAG_EN... (macro MULDIV_DIV0_FLAG_EN): busy 1 cycle, div0=1 with done. Start asserted during busy is ignored.
